// File: rtl/epmp_stack_unit_pkg.sv
// Shared EPMP definitions: bus width, default stack depth, debug-mode codes and the
// stack operation decode used by epmp_stack_unit.
package epmp_stack_unit_pkg;

  localparam int EPMP_DATA_W      = 8;
  localparam int EPMP_STACK_DEPTH = 16;

  // Debug stepping modes, numbered to match the control unit.
  typedef enum logic [1:0] {
    DBG_RUN   = 2'd0,
    DBG_ISTEP = 2'd1,
    DBG_MSTEP = 2'd2,
    DBG_USTEP = 2'd3
  } dbg_mode_e;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  // Simultaneous push+pop rewrites the top entry, or degrades to a push on an empty stack.
  function automatic stack_op_e decode_op(input logic exec_en, input logic push,
                                          input logic pop, input logic empty);
    if (!exec_en)     return OP_NONE;
    if (push && pop)  return empty ? OP_PUSH : OP_REPLACE;
    if (push)         return OP_PUSH;
    if (pop)          return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/epmp_stack_unit_if.sv
// Internal-bus / control-unit strobe bundle between the EPMP control unit and the stack.
interface epmp_stack_unit_if
  import epmp_stack_unit_pkg::*;
#(
  parameter int DATA_W = EPMP_DATA_W
);
  logic              Exec_En;
  logic              Push_Stack;
  logic              Pop_Stack;
  logic [DATA_W-1:0] Din;
  logic [DATA_W-1:0] Dout;
  logic              Out_En;

  modport master (
    output Exec_En, Push_Stack, Pop_Stack, Din,
    input  Dout, Out_En
  );

  modport slave (
    input  Exec_En, Push_Stack, Pop_Stack, Din,
    output Dout, Out_En
  );
endinterface

// File: rtl/epmp_stack_ram.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port and
// NRD combinational read ports. Contents are never cleared.
module epmp_stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int NRD    = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr [NRD],
  output logic [DATA_W-1:0] rdata [NRD]
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DEPTH is a power of two, so every AW-bit address is in range.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      assign rdata[gi] = mem[raddr[gi]];
    end
  endgenerate

endmodule

// File: rtl/epmp_stack_unit.sv
// EPMP hardware LIFO on the internal bus: pointer, full/empty, sticky error flags.
// Optional EPMP_STACK_DEBUG_EN adds Dbg_Addr/Dbg_Data array peek and Dbg_Peak high-water mark.
module epmp_stack_unit
  import epmp_stack_unit_pkg::*;
#(
  parameter int DATA_W = EPMP_DATA_W,
  parameter int DEPTH  = EPMP_STACK_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              Reset,
  epmp_stack_unit_if.slave  bus,
  output logic [PTR_W-1:0]  SP,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow,
  output logic              Underflow
`ifdef EPMP_STACK_DEBUG_EN
  ,
  input  logic [PTR_W-2:0]  Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data,
  output logic [PTR_W-1:0]  Dbg_Peak
`endif
);

  localparam int AW = PTR_W - 1;
`ifdef EPMP_STACK_DEBUG_EN
  localparam int NRD = 2;
`else
  localparam int NRD = 1;
`endif

  logic [PTR_W-1:0]  sp_reg, sp_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              empty, full;
  stack_op_e         op;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     rd_addr [NRD];
  logic [DATA_W-1:0] rd_data [NRD];

  assign empty   = (sp_reg == '0);
  assign full    = (sp_reg == PTR_W'(DEPTH));
  assign top_idx = AW'(sp_reg - PTR_W'(1));
  assign op      = decode_op(bus.Exec_En, bus.Push_Stack, bus.Pop_Stack, empty);

  always_comb begin
    sp_next        = sp_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    wr_en          = 1'b0;
    wr_addr        = sp_reg[AW-1:0];
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_next = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp_reg + PTR_W'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_next = 1'b1;
        end else begin
          sp_next = sp_reg - PTR_W'(1);
        end
      end
      OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
      default: ;
    endcase
    // Reset must also suppress a same-cycle array write.
    if (Reset) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign rd_addr[0] = top_idx;

  epmp_stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (bus.Din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign bus.Dout   = empty ? '0 : rd_data[0];
  assign bus.Out_En = bus.Pop_Stack && !empty;
  assign SP         = sp_reg;
  assign Empty      = empty;
  assign Full       = full;
  assign Overflow   = overflow_reg;
  assign Underflow  = underflow_reg;

`ifdef EPMP_STACK_DEBUG_EN
  logic [PTR_W-1:0] peak_reg;

  always_ff @(posedge clk) begin
    if (Reset) begin
      peak_reg <= '0;
    end else if (sp_next > peak_reg) begin
      peak_reg <= sp_next;
    end
  end

  assign rd_addr[1] = Dbg_Addr;
  assign Dbg_Data   = rd_data[1];
  assign Dbg_Peak   = peak_reg;
`endif

endmodule

// File: tb/tb_epmp_stack_unit.sv
// Directed bench for epmp_stack_unit (DATA_W=8, DEPTH=16) with hand-computed expectations.
module tb_epmp_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 5;

  logic             clk;
  logic             Reset;
  logic [PTR_W-1:0] sp;
  logic             empty, full, overflow, underflow;
`ifdef EPMP_STACK_DEBUG_EN
  logic [PTR_W-2:0]  dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [PTR_W-1:0]  dbg_peak;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  epmp_stack_unit_if #(.DATA_W(DATA_W)) bus ();

  epmp_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (bus),
    .SP        (sp),
    .Empty     (empty),
    .Full      (full),
    .Overflow  (overflow),
    .Underflow (underflow)
`ifdef EPMP_STACK_DEBUG_EN
    ,
    .Dbg_Addr  (dbg_addr),
    .Dbg_Data  (dbg_data),
    .Dbg_Peak  (dbg_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic pop, input logic [7:0] din, input logic en);
    bus.Push_Stack = push;
    bus.Pop_Stack  = pop;
    bus.Din        = din;
    bus.Exec_En    = en;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sp !== 5'd0) begin n_fail++; $display("FAIL reset_sp: got %0d expected 0", sp); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
    n_checks++; if (bus.Dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.Dout); end
    $display("test_reset: sp=%0d empty=%b dout=%h", sp, empty, bus.Dout);
  endtask

  task automatic test_push_pop();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vals[i], 1'b1);
      tick();
      $display("push %h -> sp=%0d dout=%h", vals[i], sp, bus.Dout);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    n_checks++; if (sp !== 5'd3) begin n_fail++; $display("FAIL push3_sp: got %0d expected 3", sp); end
    n_checks++; if (bus.Dout !== 8'h33) begin n_fail++; $display("FAIL push3_dout: got %h expected 33", bus.Dout); end
    for (int i = 2; i >= 0; i--) begin
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      #1;
      n_checks++; if (bus.Dout !== vals[i]) begin n_fail++; $display("FAIL pop_dout[%0d]: got %h expected %h", i, bus.Dout, vals[i]); end
      n_checks++; if (bus.Out_En !== 1'b1) begin n_fail++; $display("FAIL pop_out_en[%0d]: got %b expected 1", i, bus.Out_En); end
      $display("pop -> dout=%h out_en=%b", bus.Dout, bus.Out_En);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    n_checks++; if (empty !== 1'b1 || sp !== 5'd0) begin n_fail++; $display("FAIL pop3_empty: got empty=%b sp=%0d expected 1 0", empty, sp); end
    n_checks++; if (bus.Dout !== 8'h00) begin n_fail++; $display("FAIL pop3_dout: got %h expected 00", bus.Dout); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1);
      tick();
      if (i == 15) begin
        n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill16: got full=%b ovf=%b expected 1 0", full, overflow); end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    $display("push x17 -> sp=%0d full=%b ovf=%b dout=%h", sp, full, overflow, bus.Dout);
    n_checks++; if (sp !== 5'd16) begin n_fail++; $display("FAIL ovf_sp: got %0d expected 16", sp); end
    n_checks++; if (full !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flags: got full=%b ovf=%b expected 1 1", full, overflow); end
    n_checks++; if (bus.Dout !== 8'h0F) begin n_fail++; $display("FAIL ovf_dout: got %h expected 0f", bus.Dout); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_unf: got %b expected 0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    #1;
    n_checks++; if (bus.Out_En !== 1'b0) begin n_fail++; $display("FAIL unf_out_en: got %b expected 0", bus.Out_En); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    $display("pop empty -> sp=%0d unf=%b", sp, underflow);
    n_checks++; if (underflow !== 1'b1 || sp !== 5'd0) begin n_fail++; $display("FAIL unf_flag: got unf=%b sp=%0d expected 1 0", underflow, sp); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL unf_ovf: got %b expected 0", overflow); end
    tick();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b expected 1", underflow); end
    do_reset();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_step_gating();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'hA5, (i == 1));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    $display("step push -> sp=%0d dout=%h", sp, bus.Dout);
    n_checks++; if (sp !== 5'd1) begin n_fail++; $display("FAIL step_sp: got %0d expected 1", sp); end
    n_checks++; if (bus.Dout !== 8'hA5) begin n_fail++; $display("FAIL step_dout: got %h expected a5", bus.Dout); end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    tick();
    n_checks++; if (bus.Out_En !== 1'b1 || bus.Dout !== 8'hA5) begin n_fail++; $display("FAIL step_hold_bus: got out_en=%b dout=%h expected 1 a5", bus.Out_En, bus.Dout); end
    n_checks++; if (sp !== 5'd1) begin n_fail++; $display("FAIL step_hold_sp: got %0d expected 1", sp); end
  endtask

  task automatic test_push_pop_both();
    do_reset();
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    #1;
    n_checks++; if (bus.Out_En !== 1'b0) begin n_fail++; $display("FAIL both_empty_out_en: got %b expected 0", bus.Out_En); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    n_checks++; if (sp !== 5'd1 || bus.Dout !== 8'h77 || underflow !== 1'b0) begin n_fail++; $display("FAIL both_empty: got sp=%0d dout=%h unf=%b expected 1 77 0", sp, bus.Dout, underflow); end
    do_reset();
    drive(1'b1, 1'b0, 8'h11, 1'b1); tick();
    drive(1'b1, 1'b0, 8'h22, 1'b1); tick();
    drive(1'b1, 1'b1, 8'h99, 1'b1);
    #1;
    n_checks++; if (bus.Dout !== 8'h22) begin n_fail++; $display("FAIL both_during: got %h expected 22", bus.Dout); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    $display("push+pop 99 -> sp=%0d dout=%h", sp, bus.Dout);
    n_checks++; if (sp !== 5'd2) begin n_fail++; $display("FAIL both_sp: got %0d expected 2", sp); end
    n_checks++; if (bus.Dout !== 8'h99) begin n_fail++; $display("FAIL both_after: got %h expected 99", bus.Dout); end
    drive(1'b0, 1'b1, 8'h00, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    n_checks++; if (bus.Dout !== 8'h11 || sp !== 5'd1) begin n_fail++; $display("FAIL both_below: got dout=%h sp=%0d expected 11 1", bus.Dout, sp); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h50 + 8'(i), 1'b1);
      tick();
    end
`ifdef EPMP_STACK_DEBUG_EN
    n_checks++; if (dbg_peak !== 5'd5) begin n_fail++; $display("FAIL dbg_peak5: got %0d expected 5", dbg_peak); end
`endif
    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    $display("reset+push -> sp=%0d empty=%b", sp, empty);
    n_checks++; if (sp !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_prio_sp: got sp=%0d empty=%b expected 0 1", sp, empty); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rst_prio_flags: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
`ifdef EPMP_STACK_DEBUG_EN
    dbg_addr = 4'd4;
    dbg_peak_check: begin
      #1;
      n_checks++; if (dbg_data !== 8'h54) begin n_fail++; $display("FAIL dbg_data4: got %h expected 54", dbg_data); end
      n_checks++; if (dbg_peak !== 5'd0) begin n_fail++; $display("FAIL dbg_peak0: got %0d expected 0", dbg_peak); end
      dbg_addr = 4'd5;
      #1;
      n_checks++; if (dbg_data === 8'hEE) begin n_fail++; $display("FAIL dbg_data5: got %h expected not ee", dbg_data); end
    end
`endif
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef EPMP_STACK_DEBUG_EN
    dbg_addr = '0;
`endif
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_step_gating();
    test_push_pop_both();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/epmp_stack_unit.md
Name: epmp_stack_unit

Overview:
- Hardware LIFO on the EPMP internal data bus.
- Consumes the control unit's Push_Stack / Pop_Stack strobes, gated by the control unit's execution-enable, so debug single-step modes never double-push or double-pop.
- Push captures the internal-bus byte (ACC output). Pop drives the top entry onto the internal bus for the same cycle's register load.
- Keeps the stack pointer, full/empty status and sticky error flags for the debug panel.

Parameters:
- DATA_W, 8, width of one stack entry (internal bus width).
- DEPTH, 16, number of entries; must be a power of two, 2..256.
- PTR_W, $clog2(DEPTH)+1, pointer width; the extra bit distinguishes full from empty.

Ports:
- clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Exec_En  input  1  execution enable from control unit; stack state changes only when high
- Push_Stack  input  1  push request (control-unit state StPush1)
- Pop_Stack  input  1  pop request (control-unit state StPop1)
- Din  input  DATA_W  internal-bus data to push
- Dout  output  DATA_W  top-of-stack value; 0 when empty
- Out_En  output  1  bus drive enable: Pop_Stack && !Empty
- SP  output  PTR_W  entry count (0..DEPTH)
- Empty  output  1  SP==0
- Full  output  1  SP==DEPTH
- Overflow  output  1  sticky: push attempted while Full
- Underflow  output  1  sticky: pop attempted while Empty

Behaviour:
- Reset (synchronous, wins over everything):
  - SP=0, Overflow=0, Underflow=0.
  - Array contents are not cleared; Dout reads 0 because Empty=1.
- Dout is combinational from registered storage: mem[SP-1] when !Empty. Data is valid in the same cycle Pop_Stack is asserted; zero added latency.
- Push (Push_Stack && !Pop_Stack && Exec_En) at a posedge:
  - If !Full: mem[SP] <= Din, SP <= SP+1.
  - If Full: no write, SP unchanged, Overflow <= 1.
- Pop (Pop_Stack && !Push_Stack && Exec_En) at a posedge:
  - If !Empty: SP <= SP-1; the entry stays in the array.
  - If Empty: SP unchanged, Underflow <= 1.
- Push and Pop both high (illegal from the control unit; defined anyway) with Exec_En:
  - If !Empty: replace top, mem[SP-1] <= Din, SP unchanged. Dout in that cycle still shows the old top.
  - If Empty: treat as push.
- Exec_En low: no state change. Dout and Out_En still follow the inputs, so the bus value is stable while the control unit holds a state in step mode.
- Strobe held high for N enabled cycles performs N operations; no edge detection.
- Out_En asserts only while a pop is requested and data exists. An underflowing pop never drives the bus.
- Overflow and Underflow clear only on Reset.
- No wrap-around: SP saturates at 0 and DEPTH.
- Internal states: Empty (SP=0), Partial, Full (SP=DEPTH); transitions only via push/pop as above.
- Reset asserted in the same cycle as a push or pop: reset wins; SP=0 next cycle.

Optional Feature:
- Macro: EPMP_STACK_DEBUG_EN.
- Defined: adds ports Dbg_Addr (input, PTR_W-1 bits) and Dbg_Data (output, DATA_W).
  - Dbg_Data = mem[Dbg_Addr], combinational, for any index regardless of SP.
  - Adds Dbg_Peak (output, PTR_W): high-water mark of SP since reset.
- Undefined: these ports and the high-water register do not exist; core behaviour is identical.

Decomposition:
- Shared package / include (epmp_pkg.vh): EPMP_DATA_W=8, default stack depth, debug-mode codes (istep=1, mstep=2, ustep=3) shared with the control unit.
- Sub-module epmp_stack_ram: DEPTH x DATA_W register array, one synchronous write port, combinational read ports (top and debug).
- Pointer, flag and arbitration logic stays in epmp_stack_unit.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with Exec_En=1 -> SP=3; Dout=0x33. Pop x3 -> Dout 0x33, 0x22, 0x11 in the pop cycles; Out_En=1 each time; final Empty=1, Dout=0.
- DEPTH=16: push 17 values 0x00..0x10 -> SP=16, Full=1, Overflow=1 after the 17th; Dout=0x0F.
- Pop on empty stack -> Underflow=1, Out_En=0, SP stays 0. A subsequent Reset clears Underflow.
- Step gating: Push_Stack held high 4 cycles with Exec_En pulsed once, Din=0xA5 -> exactly one push, SP=1, Dout=0xA5.
- Simultaneous Push and Pop with SP=2, top=0x22, Din=0x99 -> SP=2, Dout=0x22 during the cycle, Dout=0x99 after.
- Reset asserted alongside a push at SP=5 -> SP=0, Empty=1, flags 0. With EPMP_STACK_DEBUG_EN: Dbg_Addr=4 still returns the previously stored value; Dbg_Peak=0.
